// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial: digit-serial BCD add/subtract with sign-magnitude result and start/busy/done handshake
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                sign,
  output logic                carry,
  output logic                err
);
  localparam int W = 4*DIGITS;
  localparam int CW = $clog2(DIGITS);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, nxt;
  logic [W-1:0] ra, rb, work, work_n;
  logic [CW-1:0] cnt;
  logic [3:0] x, y, dig;
  logic [4:0] s, d;
  logic rmode, w, cy, sub, bad, last;
  assign last = cnt == CW'(DIGITS-1);
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
  end
  // FIX reuses the subtractor as 0 - r_k - w to ten's-complement the working register
  always_comb begin
    sub = state == FIX || rmode;
    x = state == FIX ? 4'd0 : ra[{cnt, 2'b00} +: 4];
    y = state == FIX ? work[{cnt, 2'b00} +: 4] : rb[{cnt, 2'b00} +: 4];
    s = {1'b0, x} + {1'b0, y} + {4'b0, w};
    d = {1'b0, x} - {1'b0, y} - {4'b0, w};
    cy = sub ? d[4] : s > 5'd9;
    dig = sub ? (d[4] ? 4'(d + 5'd10) : d[3:0]) : (s > 5'd9 ? 4'(s - 5'd10) : s[3:0]);
    work_n = work;
    work_n[{cnt, 2'b00} +: 4] = dig;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (start ? (bad ? DONE : CALC) : IDLE) :
          state == CALC ? (last ? (rmode && cy ? FIX : DONE) : CALC) :
          state == FIX  ? (last ? DONE : FIX) : IDLE;
  always_comb begin
    busy = state == CALC || state == FIX;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      rmode <= 1'b0;
      w <= 1'b0;
      cnt <= '0;
      work <= '0;
      result <= '0;
      sign <= 1'b0;
      carry <= 1'b0;
      err <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        ra <= a;
        rb <= b;
        rmode <= mode;
        cnt <= '0;
        w <= 1'b0;
        work <= '0;
      end
      if (start && bad) begin
        result <= '0;
        sign <= 1'b0;
        carry <= 1'b0;
        err <= 1'b1;
      end
    end else if (busy) begin
      work <= work_n;
      w <= state == CALC && nxt == FIX ? 1'b0 : cy;
      cnt <= last ? '0 : cnt + 1'b1;
      if (nxt == DONE) begin
        result <= work_n;
        sign <= state == FIX;
        carry <= state == CALC && !rmode && cy;
        err <= 1'b0;
      end
    end
endmodule
